// File: rtl/softmax_pkg.sv
// softmax_pkg: shared sizing, core latency and FP32 helpers for the
// softmax output side (beat type, exponent field position/mask).
package softmax_pkg;

  localparam int SM_WORD_W            = 32;
  localparam int SM_PARALLEL_FACTOR   = 8;
  localparam int SM_TOTAL_WORDS       = 16;
  localparam int SM_FIFO_DEPTH        = 4;
  localparam int SOFTMAX_PIPE_LATENCY = 40;

  localparam int FP32_EXP_LSB = 23;
  localparam int FP32_EXP_W   = 8;
  localparam logic [FP32_EXP_W-1:0] FP32_EXP_MASK = 8'hFF;

  typedef logic [SM_PARALLEL_FACTOR*SM_WORD_W-1:0] beat_t;

  // All-ones exponent: NaN or +/-Inf.
  function automatic logic fp32_nan_inf(input logic [31:0] w);
    return w[FP32_EXP_LSB +: FP32_EXP_W] == FP32_EXP_MASK;
  endfunction

endpackage

// File: rtl/softmax_drain_valid_delay.sv
// valid_delay: DEPTH-stage shift line for a single valid bit.
// Ports: clk, rst (async high), d_i in, q_o = d_i delayed DEPTH cycles.
module valid_delay
  import softmax_pkg::*;
#(
  parameter int DEPTH = SOFTMAX_PIPE_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/softmax_drain.sv
// softmax_drain: captures valid core beats into a beat FIFO and serializes
// them into a 32-bit word stream with valid/ready and vector-end marking.
// Ports: clk, rst (async high), in_valid, core_data (beat) in;
//   out_data/out_valid/out_last/out_err with out_ready handshake;
//   fifo_level (beats stored), overflow (sticky drop flag).
// Option: SOFTMAX_DRAIN_NAN_FLAG_EN stores a per-lane NaN/Inf flag
//   with each beat and drives out_err; otherwise out_err is tied 0.
module softmax_drain
  import softmax_pkg::*;
#(
  parameter int PARALLEL_FACTOR = SM_PARALLEL_FACTOR,
  parameter int WORD_W          = SM_WORD_W,
  parameter int TOTAL_WORDS     = SM_TOTAL_WORDS,
  parameter int PIPE_LATENCY    = SOFTMAX_PIPE_LATENCY,
  parameter int FIFO_DEPTH      = SM_FIFO_DEPTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic [PARALLEL_FACTOR*WORD_W-1:0] core_data,
  output logic [WORD_W-1:0]                 out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              out_err,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              overflow
);

  localparam int BW  = PARALLEL_FACTOR * WORD_W;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int LNW = (PARALLEL_FACTOR > 1) ? $clog2(PARALLEL_FACTOR) : 1;
  localparam int WCW = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;

  localparam logic [LNW-1:0] LANE_LAST = LNW'(PARALLEL_FACTOR - 1);
  localparam logic [WCW-1:0] WCNT_LAST = WCW'(TOTAL_WORDS - 1);
  localparam logic [LW-1:0]  LVL_FULL  = LW'(FIFO_DEPTH);

  logic              cap_valid;
  logic [BW-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     level_d;
  logic [LNW-1:0]    lane_q;
  logic [WCW-1:0]    wcnt_q;
  logic              ovf_q;
  logic              vld_q;
  logic [WORD_W-1:0] data_q;
  logic [WORD_W-1:0] head_lanes [PARALLEL_FACTOR];
  logic [WORD_W-1:0] head_word;
  logic              empty;
  logic              full;
  logic              advance;
  logic              load;
  logic              pop;
  logic              push;
  logic              accept;

  // The core carries no valid of its own; match its latency here.
  valid_delay #(
    .DEPTH (PIPE_LATENCY)
  ) u_valid_delay (
    .clk (clk),
    .rst (rst),
    .d_i (in_valid),
    .q_o (cap_valid)
  );

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_FULL);
  assign accept  = vld_q && out_ready;
  // Output register may take a new word when empty or being accepted.
  assign advance = !vld_q || out_ready;
  assign load    = advance && !empty;
  assign pop     = load && (lane_q == LANE_LAST);
  // A pop on the same edge frees the slot a full FIFO needs.
  assign push    = cap_valid && (!full || pop);

  always_comb begin
    for (int i = 0; i < PARALLEL_FACTOR; i++) begin
      head_lanes[i] = mem_q[rd_ptr_q][i*WORD_W +: WORD_W];
    end
  end

  assign head_word = head_lanes[lane_q];

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= core_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      lane_q   <= '0;
      wcnt_q   <= '0;
      ovf_q    <= 1'b0;
      vld_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      level_q <= level_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (cap_valid && full && !pop) begin
        ovf_q <= 1'b1;
      end
      if (load) begin
        lane_q <= (lane_q == LANE_LAST) ? '0 : lane_q + LNW'(1);
      end
      if (accept) begin
        wcnt_q <= (wcnt_q == WCNT_LAST) ? '0 : wcnt_q + WCW'(1);
      end
      if (advance) begin
        vld_q <= !empty;
        if (!empty) begin
          data_q <= head_word;
        end
      end
    end
  end

  assign out_data   = data_q;
  assign out_valid  = vld_q;
  assign out_last   = vld_q && (wcnt_q == WCNT_LAST);
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

`ifdef SOFTMAX_DRAIN_NAN_FLAG_EN
  logic [PARALLEL_FACTOR-1:0] flag_mem_q [FIFO_DEPTH];
  logic [PARALLEL_FACTOR-1:0] flag_w;
  logic                       err_q;

  always_comb begin
    flag_w = '0;
    for (int i = 0; i < PARALLEL_FACTOR; i++) begin
      flag_w[i] = fp32_nan_inf(core_data[i*WORD_W +: WORD_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      flag_mem_q[wr_ptr_q] <= flag_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (advance) begin
      err_q <= !empty && flag_mem_q[rd_ptr_q][lane_q];
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_softmax_drain.sv
// tb_softmax_drain: directed vectors for softmax_drain with a simple
// latency-matched core model feeding core_data.
module tb_softmax_drain;

  localparam int PF = 8;
  localparam int W  = 32;
  localparam int L  = 40;
  localparam int BW = PF * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic          out_valid;
  logic          out_last;
  logic          out_err;
  logic          overflow;
  logic [BW-1:0] core_data;
  logic [BW-1:0] beat_in;
  logic [W-1:0]  out_data;
  logic [2:0]    fifo_level;
  logic [BW-1:0] core_pipe [L];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic        rdy;
    int          reps;
    logic        vld;
    logic [31:0] data;
    logic        last;
  } vec_t;

  vec_t tab[$];

  softmax_drain dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .core_data  (core_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .out_err    (out_err),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Core model: data presented with in_valid emerges L cycles later.
  always @(posedge clk) begin
    core_pipe[0] <= beat_in;
    for (int k = 1; k < L; k++) core_pipe[k] <= core_pipe[k-1];
  end
  assign core_data = core_pipe[L-1];

  initial begin
    #500000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [BW-1:0] mk(input logic [31:0] base);
    logic [BW-1:0] r;
    for (int i = 0; i < PF; i++) r[i*W +: W] = base + 32'(i);
    return r;
  endfunction

  function automatic logic exp_err(input logic [31:0] d);
`ifdef SOFTMAX_DRAIN_NAN_FLAG_EN
    return d[30:23] == 8'hFF;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void add(input logic rdy, input int reps,
                              input logic vld, input logic [31:0] data,
                              input logic last);
    vec_t v;
    v.rdy  = rdy;
    v.reps = reps;
    v.vld  = vld;
    v.data = data;
    v.last = last;
    tab.push_back(v);
  endfunction

  task automatic run_table(input string tag);
    foreach (tab[r]) begin
      for (int k = 0; k < tab[r].reps; k++) begin
        out_ready = tab[r].rdy;
        chk({tag, "_vld"}, 32'(out_valid), 32'(tab[r].vld));
        if (tab[r].vld) begin
          chk({tag, "_data"}, out_data, tab[r].data);
          chk({tag, "_last"}, 32'(out_last), 32'(tab[r].last));
          chk({tag, "_err"}, 32'(out_err), 32'(exp_err(tab[r].data)));
        end
        tick();
      end
    end
    tab.delete();
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!out_valid && k < budget) begin
      tick();
      k++;
    end
    chk("wait_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    beat_in   = '1;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    logic [BW-1:0] bc;
    int            cnt;
    int            seen;

    // Reset values
    in_valid  = 1'b0;
    out_ready = 1'b0;
    beat_in   = '1;
    rst       = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_err", 32'(out_err), 0);
    chk("rst_data", out_data, 0);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    cyc = 0;

    // Latency, two-beat vector, mid-beat stall
    out_ready = 1'b1;
    in_valid  = 1'b1;
    beat_in   = mk(32'h3F800000);
    tick();
    beat_in = mk(32'h40000000);
    tick();
    in_valid = 1'b0;
    beat_in  = '1;
    while (cyc < L + 1) tick();
    chk("lat_early", 32'(out_valid), 0);
    tick();
    chk("lat_rise", 32'(out_valid), 1);
    for (int i = 0; i < 3; i++) add(1, 1, 1, 32'h3F800000 + 32'(i), 0);
    add(0, 20, 1, 32'h3F800003, 0);
    for (int i = 3; i < 8; i++) add(1, 1, 1, 32'h3F800000 + 32'(i), 0);
    for (int i = 0; i < 7; i++) add(1, 1, 1, 32'h40000000 + 32'(i), 0);
    add(1, 1, 1, 32'h40000007, 1);
    add(1, 3, 0, 0, 0);
    run_table("ab");

    // Second vector after wrap, with a NaN lane
    bc = mk(32'h3F000000);
    bc[5*W +: W] = 32'h7FC00000;
    in_valid = 1'b1;
    beat_in  = bc;
    tick();
    beat_in = mk(32'h41000000);
    tick();
    in_valid = 1'b0;
    beat_in  = '1;
    wait_valid(60);
    for (int i = 0; i < 8; i++) add(1, 1, 1, bc[i*W +: W], 0);
    for (int i = 0; i < 7; i++) add(1, 1, 1, 32'h41000000 + 32'(i), 0);
    add(1, 1, 1, 32'h41000007, 1);
    add(1, 2, 0, 0, 0);
    run_table("cd");

    // Overflow: 8 back-to-back beats, consumer stalled
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      in_valid = 1'b1;
      beat_in  = mk(32'h50000000 + 32'(e) * 256);
      tick();
    end
    in_valid = 1'b0;
    beat_in  = '1;
    while (cyc < L) tick();
    for (int e = L + 1; e <= L + 8; e++) begin
      tick();
      chk("ovf_level", 32'(fifo_level), (e - L < 4) ? 32'(e - L) : 32'd4);
      chk("ovf_flag", 32'(overflow), 32'(e >= L + 5));
    end
    tick();
    chk("ovf_hold", 32'(overflow), 1);
    out_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 45; k++) begin
      if (out_valid) begin
        chk("ovf_word", out_data,
            32'h50000000 + 32'(cnt / 8 + 1) * 256 + 32'(cnt % 8));
        cnt++;
      end
      tick();
    end
    chk("ovf_count", 32'(cnt), 32);
    chk("ovf_sticky", 32'(overflow), 1);
    chk("ovf_empty", 32'(fifo_level), 0);

    // Push and pop on the same edge while full
    do_reset();
    cnt = 0;
    for (int e = 1; e <= 60; e++) begin
      in_valid  = (e <= 4) || (e == 11);
      beat_in   = in_valid ? mk(32'h60000000 + 32'(e) * 256) : '1;
      out_ready = (e >= 45);
      if (out_valid && out_ready) cnt++;
      tick();
      if (e == 50) chk("pp_level_pre", 32'(fifo_level), 4);
      if (e == 51) begin
        chk("pp_level", 32'(fifo_level), 4);
        chk("pp_ovf", 32'(overflow), 0);
      end
    end
    in_valid = 1'b0;
    beat_in  = '1;
    for (int k = 0; k < 60; k++) begin
      if (out_valid && out_ready) cnt++;
      tick();
    end
    chk("pp_words", 32'(cnt), 40);
    chk("pp_ovf_end", 32'(overflow), 0);

    // Async reset with 3 beats stored and 2 in flight
    do_reset();
    for (int e = 1; e <= 5; e++) begin
      in_valid = 1'b1;
      beat_in  = mk(32'h70000000 + 32'(e) * 256);
      tick();
    end
    in_valid = 1'b0;
    beat_in  = '1;
    while (cyc < L + 3) tick();
    chk("ar_pre_level", 32'(fifo_level), 3);
    chk("ar_pre_valid", 32'(out_valid), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_level", 32'(fifo_level), 0);
    chk("ar_data", out_data, 0);
    chk("ar_last", 32'(out_last), 0);
    chk("ar_err", 32'(out_err), 0);
    chk("ar_ovf", 32'(overflow), 0);
    #2;
    rst       = 1'b0;
    out_ready = 1'b1;
    seen      = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("ar_no_valid", 32'(seen), 0);
    chk("ar_level_end", 32'(fifo_level), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/softmax_drain.md
# softmax_drain

Output-side collector for the 8-lane softmax pipeline. It tracks which 256-bit result beats are valid by delaying the input-side valid through a latency-matched shift line. It captures valid beats into a small beat FIFO and serializes them into a 32-bit word stream with valid/ready handshake and vector-end marking. It sits between the free-running softmax core output and the downstream word consumer (DMA/host bridge).

## Interface
- PARALLEL_FACTOR, 8, lanes per beat
- WORD_W, 32, bits per word (IEEE-754 single)
- TOTAL_WORDS, 16, words per softmax vector; must be a multiple of PARALLEL_FACTOR
- PIPE_LATENCY, 40, core cycles from data_in sampled to matching data_out; ≥1
- FIFO_DEPTH, 4, beat FIFO entries; power of two, ≥2

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  high in the cycle a valid beat is presented on the core's data_in
- core_data  in  PARALLEL_FACTOR*WORD_W  core data_out; lane i = bits [i*WORD_W +: WORD_W]
- out_data  out  WORD_W  serialized word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts word when out_valid && out_ready
- out_last  out  1  with out_valid: final word of a vector
- out_err  out  1  with out_valid: word is NaN/Inf (see Configuration)
- fifo_level  out  $clog2(FIFO_DEPTH)+1  beats stored
- overflow  out  1  sticky: a valid beat was dropped

## Operation
- Valid tracking: PIPE_LATENCY-stage shift register of in_valid; tap cap_valid = last stage. No data delayed, valid only.
- Capture: cap_valid && (!full || pop) → write core_data into FIFO at the same edge. cap_valid && full && !pop → beat dropped, overflow←1 (held until rst).
- Core has no backpressure; the FIFO is the only elasticity.
- Serializer: lane counter lane (0..PARALLEL_FACTOR-1) on FIFO head. out_data = head lane `lane`, lane 0 first. out_valid = !empty.
- Handshake: out_valid && out_ready → lane++. At lane==PARALLEL_FACTOR-1, accept → pop head, lane←0.
- out_data, out_last, out_err stable while out_valid && !out_ready.
- Vector counter wcnt (0..TOTAL_WORDS-1) increments on every accepted word and wraps to 0. out_last = (wcnt==TOTAL_WORDS-1).
- Dropped beats do not advance wcnt. After overflow, vector framing is undefined until rst.
- Simultaneous push and pop at full: both occur, level unchanged. Push and pop at empty are impossible (pop requires !empty).
- fifo_level: +1 on push-only, −1 on pop-only, unchanged otherwise.

## Timing
- Reset values: out_valid 0, out_last 0, out_err 0, out_data 0, fifo_level 0, overflow 0; shift line, lane, wcnt, pointers 0.
- rst mid-operation clears all in-flight valids and stored beats immediately. Beats in the core at reset are never captured.
- in_valid high at edge t → core_data captured at edge t+PIPE_LATENCY → out_valid high after edge t+PIPE_LATENCY+1.
- With out_ready held high, a beat drains in PARALLEL_FACTOR cycles, one word per cycle, no bubbles between consecutive beats.
- Sustained throughput: 1 beat per PARALLEL_FACTOR cycles. A faster in_valid rate eventually overflows.

## Configuration
- SOFTMAX_DRAIN_NAN_FLAG_EN defined:
  - out_err = (out_data[30:23]==8'hFF) while out_valid, registered alongside the FIFO entry as a per-lane flag captured at write.
  - Adds PARALLEL_FACTOR bits per FIFO entry.
- Not defined: out_err tied 0; no extra storage.

## Structure
- Shared package softmax_pkg:
  - WORD_W, PARALLEL_FACTOR, TOTAL_WORDS defaults
  - SOFTMAX_PIPE_LATENCY constant
  - FP32 exponent field position/mask
  - a beat typedef (PARALLEL_FACTOR×WORD_W)
- One sub-module, valid_delay (parameterised shift line, async reset), instanced once. The FIFO and serializer stay inline.

## Test plan
- Single beat, lanes 0..7 = 32'h3F800000+i, PIPE_LATENCY=40, out_ready=1 → out_valid rises after edge 41; words emitted in lane order over 8 cycles; out_last=0.
- Two consecutive beats (one vector, TOTAL_WORDS=16) → 16 words; out_last high only on word 15; wcnt wraps to 0.
- out_ready held low for 20 cycles mid-beat → out_data/out_last frozen; no word lost or repeated after release.
- in_valid every cycle for 8 cycles, out_ready=0, FIFO_DEPTH=4 → fifo_level saturates at 4; 4 beats dropped; overflow=1 and stays 1.
- Push and pop on the same edge with level=4 → level stays 4, overflow stays 0.
- rst asserted asynchronously with 3 beats stored and 2 in flight → all outputs zero immediately; no out_valid afterwards. With macro: lane value 32'h7FC00000 → out_err=1 on that word only.
